// File: rtl/fp_mant_normalizer.sv
// -----------------------------------------------------------------------------
// fp_mant_normalizer
//
// Post-add normalizer for the single-precision FP adder. It is the left-shift
// counterpart of the alignment barrel shifter. It takes the raw mantissa sum,
// including the adder carry-out, and the common exponent. It returns a
// mantissa with its MSB set, the adjusted exponent, and zero/overflow/underflow
// flags.
//
// The shift is iterative: one binary-weighted step per cycle, from 2^(N-1)
// down to 1. A step is taken only when the top 2^k bits are all zero and the
// exponent can absorb the shift without reaching zero. Latency does not
// depend on the data:
//   - normal / carry path : out_valid rises NUM_STEPS cycles after the accept edge
//   - zero / overflow path: out_valid rises 1 cycle after the accept edge
//
// Ports
//   clk        in   1          clock, rising edge
//   rst_n      in   1          asynchronous reset, active low
//   in_valid   in   1          input operand valid
//   in_ready   out  1          block can accept (IDLE and not in reset)
//   in_mant    in   MANT_W+1   raw sum; bit MANT_W is the adder carry-out
//   in_exp     in   EXP_W      common (larger) exponent
//   out_valid  out  1          result valid; held until out_ready
//   out_ready  in   1          downstream accepts the result
//   out_mant   out  MANT_W     normalized mantissa
//   out_exp    out  EXP_W      adjusted exponent
//   out_zero   out  1          result is exact zero
//   out_ovf    out  1          exponent overflow (result is infinity)
//   out_unf    out  1          could not fully normalize (denormal result)
// -----------------------------------------------------------------------------
module fp_mant_normalizer #(
    parameter int MANT_W    = 24,
    parameter int EXP_W     = 8,
    parameter int NUM_STEPS = $clog2(MANT_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W:0]   in_mant,
    input  logic [EXP_W-1:0]  in_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_mant,
    output logic [EXP_W-1:0]  out_exp,
    output logic              out_zero,
    output logic              out_ovf,
    output logic              out_unf
);

    localparam int STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_STEPS - 1);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
    localparam logic [EXP_W-1:0]  EXP_MAX   = '1;
    localparam logic [EXP_W:0]    EXP_ONE_X = (EXP_W + 1)'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t            state_q,     state_d;
    logic [STEP_W-1:0] step_q,      step_d;
    logic [MANT_W-1:0] mant_q,      mant_d;
    logic [EXP_W-1:0]  exp_q,       exp_d;
    logic              out_valid_q, out_valid_d;
    logic [MANT_W-1:0] out_mant_q,  out_mant_d;
    logic [EXP_W-1:0]  out_exp_q,   out_exp_d;
    logic              out_zero_q,  out_zero_d;
    logic              out_ovf_q,   out_ovf_d;
    logic              out_unf_q,   out_unf_d;

    // -------------------------------------------------------------------------
    // Single shift step datapath (step k shifts by 2^k)
    // -------------------------------------------------------------------------
    logic [EXP_W:0]    shift_amt;
    logic [MANT_W-1:0] top_mask;
    logic              top_zero;
    logic              exp_room;
    logic              do_shift;
    logic [MANT_W-1:0] mant_step;
    logic [EXP_W-1:0]  exp_step;

    always_comb begin
        shift_amt = EXP_ONE_X << step_q;
        // The mask selects the top shift_amt bits of the mantissa.
        top_mask  = ~({MANT_W{1'b1}} >> shift_amt);
        top_zero  = ((mant_q & top_mask) == '0);
        // A strict comparison keeps the exponent at 1 or above while shifting.
        // An exponent of 0 therefore blocks every step.
        exp_room  = ({1'b0, exp_q} > shift_amt);
        do_shift  = top_zero && exp_room;
        mant_step = do_shift ? (mant_q << shift_amt) : mant_q;
        exp_step  = do_shift ? (exp_q - shift_amt[EXP_W-1:0]) : exp_q;
    end

    // -------------------------------------------------------------------------
    // Carry-path exponent, widened so that an all-ones exponent cannot wrap
    // -------------------------------------------------------------------------
    logic [EXP_W:0] exp_inc;
    logic           carry_ovf;

    always_comb begin
        exp_inc   = {1'b0, in_exp} + EXP_ONE_X;
        carry_ovf = (exp_inc >= {1'b0, EXP_MAX});
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default here, so each path through the
        // case statement is fully specified and no latch is inferred.
        state_d     = state_q;
        step_d      = step_q;
        mant_d      = mant_q;
        exp_d       = exp_q;
        out_valid_d = out_valid_q;
        out_mant_d  = out_mant_q;
        out_exp_d   = out_exp_q;
        out_zero_d  = out_zero_q;
        out_ovf_d   = out_ovf_q;
        out_unf_d   = out_unf_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_mant == '0) begin
                        out_mant_d = '0;
                        out_exp_d  = '0;
                        out_zero_d = 1'b1;
                        state_d    = DONE;
                    end else if (in_mant[MANT_W] && carry_ovf) begin
                        out_mant_d = '0;
                        out_exp_d  = EXP_MAX;
                        out_ovf_d  = 1'b1;
                        state_d    = DONE;
                    end else if (in_mant[MANT_W]) begin
                        // The carry-out becomes the new hidden bit and the LSB
                        // is dropped. The shift steps then find nothing to do,
                        // which keeps the latency the same as the normal path.
                        mant_d  = in_mant[MANT_W:1];
                        exp_d   = exp_inc[EXP_W-1:0];
                        step_d  = STEP_LAST;
                        state_d = SHIFT;
                    end else begin
                        mant_d  = in_mant[MANT_W-1:0];
                        exp_d   = in_exp;
                        step_d  = STEP_LAST;
                        state_d = SHIFT;
                    end
                end
            end

            SHIFT: begin
                mant_d = mant_step;
                exp_d  = exp_step;
                if (step_q == '0) begin
                    out_valid_d = 1'b1;
                    out_mant_d  = mant_step;
                    if (mant_step[MANT_W-1]) begin
                        out_exp_d = exp_step;
                        out_unf_d = 1'b0;
                    end else begin
                        out_exp_d = '0;
                        out_unf_d = 1'b1;
                    end
                    state_d = DONE;
                end else begin
                    step_d = step_q - STEP_ONE;
                end
            end

            DONE: begin
                // The zero/overflow shortcut arrives here with out_valid still
                // low. Raising it one cycle later gives that path its fixed
                // single-cycle latency.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_zero_d  = 1'b0;
                    out_ovf_d   = 1'b0;
                    out_unf_d   = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: every register, including the internal datapath, is cleared by
    // the asynchronous reset. An operation interrupted by reset leaves nothing
    // behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments keep all flops updating from the
            // same pre-edge values, whatever order the statements are in.
            state_q     <= IDLE;
            step_q      <= '0;
            mant_q      <= '0;
            exp_q       <= '0;
            out_valid_q <= 1'b0;
            out_mant_q  <= '0;
            out_exp_q   <= '0;
            out_zero_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_unf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            mant_q      <= mant_d;
            exp_q       <= exp_d;
            out_valid_q <= out_valid_d;
            out_mant_q  <= out_mant_d;
            out_exp_q   <= out_exp_d;
            out_zero_q  <= out_zero_d;
            out_ovf_q   <= out_ovf_d;
            out_unf_q   <= out_unf_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // rst_n is included so that in_ready drops as soon as reset asserts.
    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_mant  = out_mant_q;
    assign out_exp   = out_exp_q;
    assign out_zero  = out_zero_q;
    assign out_ovf   = out_ovf_q;
    assign out_unf   = out_unf_q;

`ifndef SYNTHESIS
    // A result that is offered but not yet taken must not change.
    assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid_q && !out_ready) |=>
            (out_valid_q && $stable(out_mant_q) && $stable(out_exp_q) &&
             $stable(out_zero_q) && $stable(out_ovf_q) && $stable(out_unf_q)));

    // Operations never overlap.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(in_ready && out_valid_q));
`endif

endmodule

// File: tb/tb_fp_mant_normalizer.sv
// -----------------------------------------------------------------------------
// tb_fp_mant_normalizer
//
// Scoreboard bench for fp_mant_normalizer. The driver pushes the result and
// latency predicted by an arithmetic reference model for every accepted
// operand. An independent monitor pops a prediction each time a new result is
// presented. While that result is held, the monitor checks on every cycle that
// it stays equal to the prediction.
// -----------------------------------------------------------------------------
module tb_fp_mant_normalizer;

    localparam int MANT_W    = 24;
    localparam int EXP_W     = 8;
    localparam int NUM_STEPS = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [MANT_W:0]   in_mant;
    logic [EXP_W-1:0]  in_exp;
    logic              out_valid;
    logic              out_ready;
    logic [MANT_W-1:0] out_mant;
    logic [EXP_W-1:0]  out_exp;
    logic              out_zero;
    logic              out_ovf;
    logic              out_unf;

    fp_mant_normalizer #(
        .MANT_W    (MANT_W),
        .EXP_W     (EXP_W),
        .NUM_STEPS (NUM_STEPS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mant   (in_mant),
        .in_exp    (in_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_exp   (out_exp),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [MANT_W-1:0] mant;
        logic [EXP_W-1:0]  exp;
        logic              zero;
        logic              ovf;
        logic              unf;
        int                lat;
        int                acc_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit   seen = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   rdy_mode = 1;   // 0: random, 1: always ready, 2: never ready

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: shift left by the leading-zero count, but never so far
    // that the exponent would drop below 1. If the hidden bit is still clear
    // afterwards, the result is denormal and the exponent is reported as 0.
    function automatic exp_t model(input logic [MANT_W:0] m, input logic [EXP_W-1:0] e);
        exp_t r;
        int   mv, ev, lz, sh;
        r.mant = '0; r.exp = '0; r.zero = 1'b0; r.ovf = 1'b0; r.unf = 1'b0;
        r.lat = NUM_STEPS; r.acc_cyc = 0;
        if (m == '0) begin
            r.zero = 1'b1;
            r.lat  = 1;
            return r;
        end
        if (m[MANT_W]) begin
            if (int'(e) + 1 == 255) begin
                r.ovf = 1'b1;
                r.exp = 8'hFF;
                r.lat = 1;
                return r;
            end
            mv = int'(m >> 1);
            ev = int'(e) + 1;
        end else begin
            mv = int'(m);
            ev = int'(e);
        end
        lz = 0;
        while (lz < MANT_W && !mv[MANT_W-1-lz]) lz++;
        sh = (ev == 0) ? 0 : ((lz < ev - 1) ? lz : ev - 1);
        mv = (mv << sh) & 32'h00FF_FFFF;
        ev = ev - sh;
        r.mant = mv[MANT_W-1:0];
        if (!mv[MANT_W-1]) begin
            r.unf = 1'b1;
            r.exp = '0;
        end else begin
            r.exp = ev[EXP_W-1:0];
        end
        return r;
    endfunction

    // Issue one operand. The expectation is pushed in the cycle it is offered.
    task automatic send(input logic [MANT_W:0] m, input logic [EXP_W-1:0] e);
        exp_t x;
        int   n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: in_ready never rose within 100 cycles");
            return;
        end
        in_valid = 1'b1;
        in_mant  = m;
        in_exp   = e;
        x = model(m, e);
        x.acc_cyc = cyc + 1;
        sb.push_back(x);
        @(negedge clk);
        in_valid = 1'b0;
        in_mant  = 25'($urandom);   // ignored outside the accept cycle
        in_exp   = 8'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout: %0d results still pending", sb.size());
        end
    endtask

    // out_ready driver
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       out_ready = ($urandom_range(0, 9) < 7);
                1:       out_ready = 1'b1;
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 1'b0;
            end else if (out_valid && !seen) begin
                if (sb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_result: mant=%0h exp=%0h", out_mant, out_exp);
                end else begin
                    cur = sb.pop_front();
                    check("out_mant", 32'(out_mant), 32'(cur.mant));
                    check("out_exp",  32'(out_exp),  32'(cur.exp));
                    check("out_zero", 32'(out_zero), 32'(cur.zero));
                    check("out_ovf",  32'(out_ovf),  32'(cur.ovf));
                    check("out_unf",  32'(out_unf),  32'(cur.unf));
                    check("latency",  32'(cyc - cur.acc_cyc), 32'(cur.lat));
                end
                seen = 1'b1;
            end else if (out_valid) begin
                check("hold_mant", 32'(out_mant), 32'(cur.mant));
                check("hold_exp",  32'(out_exp),  32'(cur.exp));
                check("hold_flags", {29'd0, out_zero, out_ovf, out_unf},
                      {29'd0, cur.zero, cur.ovf, cur.unf});
            end else begin
                seen = 1'b0;
            end
        end
    end

    // Watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    initial begin
        logic [MANT_W:0]  m;
        logic [EXP_W-1:0] e;
        int               n;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_mant  = '0;
        in_exp   = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_mant",  32'(out_mant),  32'd0);
        check("rst_out_exp",   32'(out_exp),   32'd0);
        check("rst_flags", {29'd0, out_zero, out_ovf, out_unf}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Directed cases
        send(25'h0800000, 8'd100);   // already normalized
        send(25'h0000001, 8'd127);   // full 23-bit shift -> exp 104
        send(25'h1000000, 8'd100);   // carry -> exp 101
        send(25'h1800000, 8'd254);   // carry into all-ones exponent -> overflow
        send(25'h0000000, 8'd50);    // exact zero
        send(25'h0000100, 8'd5);     // exponent limits the shift -> denormal
        send(25'h0000123, 8'd0);     // zero exponent: no shift at all
        send(25'h0000002, 8'd23);    // exponent budget exactly 22
        send(25'h0000002, 8'd24);    // exponent budget exactly 23
        send(25'h1FFFFFF, 8'd253);   // carry, largest non-overflowing exponent
        drain();

        // Backpressure: result held, inputs refused, in_valid ignored
        rdy_mode  = 2;
        out_ready = 1'b0;
        send(25'h0003456, 8'd60);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("stall_result_arrived", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_mant  = 25'($urandom);
            in_exp   = 8'($urandom);
            @(negedge clk);
            check("stall_in_ready",  32'(in_ready),  32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid  = 1'b0;
        rdy_mode  = 1;
        out_ready = 1'b1;
        drain();

        // Reset in the middle of SHIFT
        send(25'h0000777, 8'd90);
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_mant",  32'(out_mant),  32'd0);
        check("midrst_out_exp",   32'(out_exp),   32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd0);
        check("midrst_flags", {29'd0, out_zero, out_ovf, out_unf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(25'h0004000, 8'd30);
        drain();

        // Randomized stream with random backpressure and idle gaps
        rdy_mode = 0;
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 7))
                0: begin
                    m = '0;
                    e = 8'($urandom);
                end
                1, 2: begin
                    m = {1'b1, 24'($urandom)};
                    e = 8'($urandom_range(0, 254));
                end
                3, 4: begin
                    m = {1'b0, 24'($urandom) >> $urandom_range(0, 23)};
                    e = 8'($urandom_range(1, 30));
                end
                default: begin
                    m = {1'b0, 24'($urandom) >> $urandom_range(0, 23)};
                    e = 8'($urandom_range(1, 255));
                end
            endcase
            send(m, e);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        rdy_mode = 1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
